// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store.
// Define ARB_STARVE_GUARD_EN to let a waiting fetch preempt data priority.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_func3,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_func3,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $error("MEM_LAT out of range");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("STARVE_MAX out of range");
  end

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t     state, state_nx;
  logic [3:0] lat_cnt, lat_nx;
  logic       own_d;
  logic       we_q;
  logic       guard;
  logic       fetch_win;
  logic       data_win;
  logic       resp;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  assign guard = (starve_cnt == 4'(STARVE_MAX));

  // count data grants that overtook a waiting fetch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (data_win) begin
      if (!if_req)
        starve_cnt <= '0;
      else if (starve_cnt != 4'(STARVE_MAX))
        starve_cnt <= starve_cnt + 4'd1;
    end else if (fetch_win) begin
      starve_cnt <= '0;
    end
  end
`else
  assign guard = 1'b0;
`endif

  // pick a winner only while idle and out of reset
  always_comb begin
    fetch_win = 1'b0;
    data_win  = 1'b0;
    if (rst && state == S_IDLE) begin
      if (if_req && (!d_req || guard))
        fetch_win = 1'b1;
      else if (d_req)
        data_win = 1'b1;
    end
  end

  // next state and latency countdown
  always_comb begin
    state_nx = state;
    lat_nx   = lat_cnt;
    unique case (state)
      S_IDLE: begin
        if (fetch_win || data_win) begin
          state_nx = S_WAIT;
          lat_nx   = 4'(MEM_LAT - 1);
        end
      end
      S_WAIT: begin
        if (lat_cnt == 4'd0)
          state_nx = S_IDLE;
        else
          lat_nx = lat_cnt - 4'd1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // state register, owner and write flag of the open transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
      own_d   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      lat_cnt <= lat_nx;
      if (fetch_win || data_win) begin
        own_d <= data_win;
        we_q  <= data_win & d_we;
      end
    end
  end

  // memory port mux from the winner
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_func3 = 3'b000;
    unique case (1'b1)
      data_win: begin
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_func3 = d_func3;
      end
      fetch_win: begin
        mem_addr  = if_addr;
        mem_func3 = 3'b010;
      end
      default: ;
    endcase
  end

  assign resp      = (state == S_WAIT) && (lat_cnt == 4'd0);
  assign if_gnt    = fetch_win;
  assign d_gnt     = data_win;
  assign mem_en    = fetch_win | data_win;
  assign if_rvalid = resp & ~own_d;
  assign d_rvalid  = resp & own_d;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;
  assign busy      = (state == S_WAIT);

endmodule
